// File: rtl/vx_lsu_amo_arbiter_pkg.sv
// Shared types and constants for the LSU atomic/memory arbiter.
package vx_gpu_pkg;

  // Arbiter ownership state: free round-robin or pinned to one requester.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int LSU_NUM_REQS = 4;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LSU_TAG_W = tag_width(LSU_NUM_REQS);

endpackage

// File: rtl/vx_lsu_amo_arbiter_if.sv
// Memory-side request/response port of the LSU atomic arbiter.
interface vx_lsu_amo_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_W      = vx_gpu_pkg::LSU_TAG_W
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic [TAG_W-1:0]      mem_req_tag;

  logic                  mem_rsp_valid;
  logic                  mem_rsp_ready;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic [TAG_W-1:0]      mem_rsp_tag;

  // Arbiter side.
  modport master (
    output mem_req_valid, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  // Memory side.
  modport slave (
    input  mem_req_valid, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_lsu_amo_arbiter_rr.sv
// Round-robin selector: first active request at or after the pointer.
// The pointer moves to one past the winner whenever a grant is taken.
module vx_rr_arbiter import vx_gpu_pkg::*; #(
  parameter int NUM_REQS = 4,
  parameter int TAG_W    = tag_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                advance,
  output logic                grant_valid,
  output logic [TAG_W-1:0]    grant_idx
);
  logic [TAG_W-1:0]      ptr_q, ptr_d;
  logic [2*NUM_REQS-1:0] dbl_sh;
  logic [NUM_REQS-1:0]   rot;
  logic [TAG_W:0]        sum;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    dbl_sh      = {req, req} >> ptr_q;
    rot         = dbl_sh[NUM_REQS-1:0];
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!grant_valid && rot[i]) begin
        grant_valid = 1'b1;
        sum = {1'b0, ptr_q} + (TAG_W+1)'(i);
        if (sum >= (TAG_W+1)'(NUM_REQS)) sum = sum - (TAG_W+1)'(NUM_REQS);
        grant_idx = sum[TAG_W-1:0];
      end
    end
  end

  // Next search starts just after the winner, wrapping to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance)
      ptr_d = (grant_idx == TAG_W'(NUM_REQS-1)) ? '0 : grant_idx + TAG_W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vx_lsu_amo_arbiter.sv
// Shares one registered atomic/memory port among NUM_REQS LSU requesters.
// Locked sequences pin the grant to one owner until its last beat; the
// outstanding counter throttles grants at MAX_PENDING.
module vx_lsu_amo_arbiter import vx_gpu_pkg::*; #(
  parameter int NUM_REQS    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_PENDING = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0]                req_lock,
  input  logic [NUM_REQS-1:0]                req_last,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQS-1:0]                req_ready,
  vx_lsu_amo_arbiter_if.master               mem,
  output logic [NUM_REQS-1:0]                rsp_valid,
  input  logic [NUM_REQS-1:0]                rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               no_pending
);
  localparam int TAG_W = tag_width(NUM_REQS);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  arb_state_e            state_q, state_d;
  logic [TAG_W-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;

  logic [NUM_REQS-1:0]   arb_req;
  logic                  grant_valid;
  logic [TAG_W-1:0]      grant_idx;
  logic                  slot_free, room, accept, mem_fire, rsp_fire;

  // While locked only the owner may compete.
  assign arb_req = (state_q == LOCKED) ? (req_valid & (NUM_REQS'(1) << owner_q)) : req_valid;

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS), .TAG_W(TAG_W)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req         (arb_req),
    .advance     (accept),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The beat held in the output register already counts against the limit,
  // so the outstanding total can never exceed MAX_PENDING. Registered count
  // only: a response frees a slot on the following cycle.
  assign slot_free = !out_valid_q || mem.mem_req_ready;
  assign room      = ({1'b0, cnt_q} + (CNT_W+1)'(out_valid_q)) < (CNT_W+1)'(MAX_PENDING);
  assign accept    = reset && slot_free && room && grant_valid;
  assign req_ready = accept ? (NUM_REQS'(1) << grant_idx) : '0;
  assign mem_fire  = out_valid_q && mem.mem_req_ready;
  assign rsp_fire  = mem.mem_rsp_valid && mem.mem_rsp_ready;

  // Output register: load on accept, drain on fire, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[grant_idx];
      out_tag_d   = grant_idx;
    end else if (mem_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Outstanding counter: simultaneous fire and response cancel.
  always_comb begin
    cnt_d = cnt_q;
    case ({mem_fire, rsp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Lock FSM; lock+last in IDLE is a plain single beat.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: if (accept && req_lock[grant_idx] && !req_last[grant_idx]) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
      LOCKED: if (accept && req_last[grant_idx]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Response steering by tag; data is broadcast.
  always_comb begin
    rsp_valid         = '0;
    mem.mem_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (mem.mem_rsp_tag == TAG_W'(i)) begin
        rsp_valid[i]      = mem.mem_rsp_valid;
        mem.mem_rsp_ready = rsp_ready[i];
      end
    end
  end

  assign rsp_data          = mem.mem_rsp_data;
  assign mem.mem_req_valid = out_valid_q;
  assign mem.mem_req_data  = out_data_q;
  assign mem.mem_req_tag   = out_tag_q;
  assign no_pending        = (cnt_q == '0) && !out_valid_q;
endmodule

// File: tb/tb_vx_lsu_amo_arbiter.sv
// Bench for the LSU atomic arbiter: routing table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_vx_lsu_amo_arbiter;
  import vx_gpu_pkg::*;

  localparam int N = 4, DW = 64, MAXP = 8, TW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]         req_valid, req_lock, req_last, req_ready;
  logic [N-1:0]         rsp_valid, rsp_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic [DW-1:0]        rsp_data;
  logic                 no_pending;
  int errors = 0;
  int checks = 0;

  vx_lsu_amo_arbiter_if #(.DATA_WIDTH(DW), .TAG_W(TW)) mem_if ();

  vx_lsu_amo_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW), .MAX_PENDING(MAXP)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .mem        (mem_if),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .no_pending (no_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] tag;
    logic [3:0] rdy;
    logic [3:0] exp_rv;
    logic       exp_mr;
  } rsp_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_lock = '0; req_last = '0; req_data = '0; rsp_ready = '0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_tag   = '0;
    mem_if.mem_rsp_data  = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_rr_order();
    do_reset();
    req_valid = 4'hF;
    mem_if.mem_req_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = 64'h100 + 64'(i);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", req_ready, 64'(4'(1) << (k % 4)));
      if (k > 0) begin
        check("rr_fire_valid", mem_if.mem_req_valid, 1);
        check("rr_tag", mem_if.mem_req_tag, 64'((k - 1) % 4));
      end
      tick();
    end
  endtask

  task automatic test_lock_seq();
    do_reset();
    mem_if.mem_req_ready = 1'b1;
    req_valid = 4'b0110; req_lock = 4'b0010; req_last = 4'b0000;
    req_data[1] = 64'hA1; req_data[2] = 64'hB2;
    #1 check("lock_b1_ready", req_ready, 4'b0010);
    tick();
    req_data[1] = 64'hA2;
    #1 check("lock_b2_ready", req_ready, 4'b0010);
    check("lock_b1_tag", mem_if.mem_req_tag, 1);
    tick();
    req_data[1] = 64'hA3; req_last = 4'b0010;
    #1 check("lock_b3_ready", req_ready, 4'b0010);
    check("lock_b2_tag", mem_if.mem_req_tag, 1);
    tick();
    req_valid = 4'b0100; req_lock = '0; req_last = '0;
    #1 check("lock_b3_tag", mem_if.mem_req_tag, 1);
    check("lock_b3_data", mem_if.mem_req_data, 64'hA3);
    check("lock_after_ready", req_ready, 4'b0100);
    tick();
    #1 check("lock_after_tag", mem_if.mem_req_tag, 2);
  endtask

  task automatic test_max_pending();
    int fires;
    fires = 0;
    do_reset();
    req_valid = 4'hF;
    mem_if.mem_req_ready = 1'b1;
    repeat (12) begin
      #1 if (mem_if.mem_req_valid && mem_if.mem_req_ready) fires++;
      tick();
    end
    #1 check("maxp_fires", 64'(fires), 8);
    check("maxp_ready_off", req_ready, 0);
    check("maxp_reg_empty", mem_if.mem_req_valid, 0);
    mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_tag = 2'd0; rsp_ready = 4'hF;
    #1 check("maxp_no_bypass", req_ready, 0);
    check("maxp_rsp_ready", mem_if.mem_rsp_ready, 1);
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    #1 check("maxp_one_grant", 64'($countones(req_ready)), 1);
    tick();
    #1 check("maxp_full_again", req_ready, 0);
    check("maxp_reg_loaded", mem_if.mem_req_valid, 1);
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b1000; req_data[3] = 64'hDEAD_BEEF_0123_4567;
    #1 check("stall_first_ready", req_ready, 4'b1000);
    tick();
    req_valid = 4'hF; req_data[3] = 64'h1111;
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_valid", mem_if.mem_req_valid, 1);
      check("stall_tag", mem_if.mem_req_tag, 3);
      check("stall_data", mem_if.mem_req_data, 64'hDEAD_BEEF_0123_4567);
      check("stall_no_accept", req_ready, 0);
      tick();
    end
    req_valid = '0; mem_if.mem_req_ready = 1'b1;
    #1 check("stall_release_tag", mem_if.mem_req_tag, 3);
    tick();
    #1 check("stall_drained", mem_if.mem_req_valid, 0);
  endtask

  task automatic test_rsp_table();
    rsp_vec_t tbl[6];
    tbl[0] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1};
    tbl[1] = '{1'b1, 2'd2, 4'b1011, 4'b0100, 1'b0};
    tbl[2] = '{1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1};
    tbl[3] = '{1'b0, 2'd1, 4'b1111, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 2'd1, 4'b1101, 4'b0010, 1'b0};
    tbl[5] = '{1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_if.mem_rsp_valid = tbl[i].v;
      mem_if.mem_rsp_tag   = tbl[i].tag;
      mem_if.mem_rsp_data  = 64'hA5A5_0000 + 64'(i);
      rsp_ready            = tbl[i].rdy;
      #1 check("tbl_rsp_valid", rsp_valid, tbl[i].exp_rv);
      check("tbl_mem_rsp_ready", mem_if.mem_rsp_ready, tbl[i].exp_mr);
      check("tbl_rsp_data", rsp_data, 64'hA5A5_0000 + 64'(i));
    end
    idle_inputs();
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    mem_if.mem_req_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    #1 check("bp_pending", no_pending, 0);
    mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_tag = 2'd1; rsp_ready = 4'b1101;
    #1 check("bp_mem_rsp_ready", mem_if.mem_rsp_ready, 0);
    check("bp_rsp_valid", rsp_valid, 4'b0010);
    tick();
    #1 check("bp_count_held", no_pending, 0);
    rsp_ready = 4'hF;
    #1 check("bp_ready_now", mem_if.mem_rsp_ready, 1);
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    #1 check("bp_count_zero", no_pending, 1);
  endtask

  task automatic test_reset_locked();
    do_reset();
    mem_if.mem_req_ready = 1'b1;
    req_valid = 4'b0100; req_lock = 4'b0100; req_last = '0;
    repeat (3) tick();
    req_valid = 4'b0101;
    #1 check("rl_lock_excl", req_ready, 4'b0100);
    tick();
    mem_if.mem_req_ready = 1'b0;
    #1 check("rl_busy_valid", mem_if.mem_req_valid, 1);
    check("rl_busy_pending", no_pending, 0);
    reset = 1'b0;
    #1 check("rl_rst_valid", mem_if.mem_req_valid, 0);
    check("rl_rst_ready", req_ready, 0);
    check("rl_rst_no_pending", no_pending, 1);
    @(posedge clk); #1;
    reset = 1'b1; req_lock = '0;
    #1 check("rl_first_grant", req_ready, 4'b0001);
  endtask

  // Randomized run; the model keeps the outstanding tags in a queue and
  // applies the grant rules (lock owner, else scan after last winner).
  task automatic run_random(input int cycles);
    int owner, last_gnt, gnt, rsp_pct, idx;
    bit out_v, mfire, rfire;
    logic [1:0] out_tag;
    logic [63:0] out_data;
    logic [3:0] exp_rdy;
    int outstanding[$];
    do_reset();
    owner = -1; last_gnt = N - 1; out_v = 0; out_tag = '0; out_data = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      rsp_pct = (cyc < cycles / 2) ? 20 : 70;
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_lock[i] = ($urandom_range(0, 2) != 0);
        req_last[i] = ($urandom_range(0, 2) == 0);
        req_data[i] = {$urandom, $urandom};
      end
      mem_if.mem_req_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = 4'($urandom);
      mem_if.mem_rsp_data = {$urandom, $urandom};
      if (outstanding.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_tag = 2'(outstanding[$urandom_range(0, outstanding.size() - 1)]);
      end else begin
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_tag = 2'($urandom);
      end

      gnt = -1;
      if ((!out_v || mem_if.mem_req_ready) && (outstanding.size() + int'(out_v) < MAXP)) begin
        if (owner >= 0) begin
          if (req_valid[owner]) gnt = owner;
        end else begin
          for (int k = 1; k <= N; k++)
            if (gnt < 0 && req_valid[(last_gnt + k) % N]) gnt = (last_gnt + k) % N;
        end
      end
      exp_rdy = (gnt >= 0) ? 4'(1) << gnt : 4'b0000;

      #1 check("rnd_req_ready", req_ready, exp_rdy);
      check("rnd_mem_valid", mem_if.mem_req_valid, out_v);
      if (out_v) begin
        check("rnd_mem_tag", mem_if.mem_req_tag, out_tag);
        check("rnd_mem_data", mem_if.mem_req_data, out_data);
      end
      check("rnd_mem_rsp_ready", mem_if.mem_rsp_ready, rsp_ready[mem_if.mem_rsp_tag]);
      check("rnd_rsp_valid", rsp_valid,
            mem_if.mem_rsp_valid ? 4'(1) << mem_if.mem_rsp_tag : 4'b0000);
      check("rnd_no_pending", no_pending, (outstanding.size() == 0) && !out_v);

      mfire = out_v && mem_if.mem_req_ready;
      rfire = mem_if.mem_rsp_valid && rsp_ready[mem_if.mem_rsp_tag];
      if (rfire) begin
        idx = -1;
        for (int q = 0; q < outstanding.size(); q++)
          if (idx < 0 && outstanding[q] == int'(mem_if.mem_rsp_tag)) idx = q;
        if (idx >= 0) outstanding.delete(idx);
      end
      if (mfire) outstanding.push_back(int'(out_tag));
      if (gnt >= 0) begin
        out_v = 1; out_tag = 2'(gnt); out_data = req_data[gnt];
        if (owner < 0 && req_lock[gnt] && !req_last[gnt]) owner = gnt;
        else if (owner >= 0 && req_last[gnt]) owner = -1;
        last_gnt = gnt;
      end else if (mfire) begin
        out_v = 0;
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    req_valid = 4'hF;
    mem_if.mem_req_ready = 1'b1;
    #1 reset = 1'b0;
    #2 check("rst_req_ready", req_ready, 0);
    check("rst_mem_valid", mem_if.mem_req_valid, 0);
    check("rst_no_pending", no_pending, 1);
    test_rr_order();
    test_lock_seq();
    test_max_pending();
    test_stall();
    test_rsp_table();
    test_rsp_backpressure();
    test_reset_locked();
    run_random(800);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
